// File: rtl/control_fsm_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared types and encodings for the multi-cycle control FSM:
//   - state_t   : FSM state encoding (also driven out on the state port)
//   - opclass_t : instruction class produced by the opclass decoder
//   - OP_*      : RV32I major opcode constants
//   - PC_*, IMM_*, ALUA_*, ALUB_*, WB_* : datapath select encodings
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_FENCE,
        CLS_ILLEGAL
    } opclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_IMM    = 2'd1;
    localparam logic [1:0] PC_ALU    = 2'd2;

    localparam logic [2:0] IMM_I     = 3'd0;
    localparam logic [2:0] IMM_S     = 3'd1;
    localparam logic [2:0] IMM_B     = 3'd2;
    localparam logic [2:0] IMM_U     = 3'd3;
    localparam logic [2:0] IMM_J     = 3'd4;

    localparam logic [1:0] ALUA_RS1  = 2'd0;
    localparam logic [1:0] ALUA_PC   = 2'd1;
    localparam logic [1:0] ALUA_ZERO = 2'd2;

    localparam logic       ALUB_RS2  = 1'b0;
    localparam logic       ALUB_IMM  = 1'b1;

    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_PC4    = 2'd2;

    // Loads and stores are the only classes that pass through MEM.
    function automatic logic isMemClass(opclass_t cls);
        return (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// ---------------------------------------------------------------------------
// control_fsm_if
// Instruction- and data-memory handshake between the control FSM and the
// memory side.
//   imem_req   : instruction fetch request        (FSM -> memory)
//   imem_valid : fetched word valid this cycle    (memory -> FSM)
//   dmem_req   : data access request              (FSM -> memory)
//   dmem_we    : data access is a write           (FSM -> memory)
//   dmem_ready : data access completes this cycle (memory -> FSM)
// The master modport is the FSM side, slave is the memory side.
// ---------------------------------------------------------------------------
interface control_fsm_if;

    logic imem_req;
    logic imem_valid;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_valid,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_valid,
        output dmem_ready
    );

endinterface

// File: rtl/control_fsm_opclass.sv
// ---------------------------------------------------------------------------
// opclass
// Purely combinational opcode decoder. Maps the 7-bit major opcode to an
// instruction class and flags whether it is a supported opcode.
//   opcode_i  : opcode field of the instruction register
//   opClass_o : decoded class (CLS_ILLEGAL for unsupported opcodes)
//   legal_o   : 1 when the opcode belongs to the supported set
// ---------------------------------------------------------------------------
module opclass
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output opclass_t   opClass_o,
    output logic       legal_o
);

    // Straight opcode lookup; anything unrecognised decodes as illegal.
    always_comb begin
        opClass_o = CLS_ILLEGAL;
        case (opcode_i)
            OP_R:      opClass_o = CLS_ALU_R;
            OP_I:      opClass_o = CLS_ALU_I;
            OP_LOAD:   opClass_o = CLS_LOAD;
            OP_STORE:  opClass_o = CLS_STORE;
            OP_BRANCH: opClass_o = CLS_BRANCH;
            OP_JAL:    opClass_o = CLS_JAL;
            OP_JALR:   opClass_o = CLS_JALR;
            OP_LUI:    opClass_o = CLS_LUI;
            OP_AUIPC:  opClass_o = CLS_AUIPC;
            OP_FENCE:  opClass_o = CLS_FENCE;
            default:   opClass_o = CLS_ILLEGAL;
        endcase
        legal_o = (opClass_o != CLS_ILLEGAL);
    end

endmodule

// File: rtl/control_fsm.sv
// ---------------------------------------------------------------------------
// control_fsm
// Multi-cycle RV32I control unit: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   OpCode, funct3     : instruction register fields (funct3 only checks JALR)
//   memBus             : imem/dmem handshake (control_fsm_if.master)
//   br_taken           : branch comparator result, used in EXEC
//   ir_we/pc_we/reg_we : instruction, PC and register-file write enables
//   pc_sel, imm_sel    : next-PC and immediate-format selects
//   alu_a_sel/alu_b_sel: ALU operand selects
//   wb_sel             : register write-back source
//   retire, instret    : retire pulse and retired-instruction count
//   trap, state        : sticky illegal-instruction flag and current state
// ---------------------------------------------------------------------------
module control_fsm
    import ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          OpCode,
    input  logic [2:0]          funct3,
    control_fsm_if.master       memBus,
    input  logic                br_taken,
    output logic                ir_we,
    output logic                pc_we,
    output logic                reg_we,
    output logic [1:0]          pc_sel,
    output logic [2:0]          imm_sel,
    output logic [1:0]          alu_a_sel,
    output logic                alu_b_sel,
    output logic [1:0]          wb_sel,
    output logic                retire,
    output logic [31:0]         instret,
    output logic                trap,
    output logic [2:0]          state
);

    state_t      state_q, state_d;
    logic [31:0] instret_q, instret_d;
    opclass_t    opClass;
    logic        opLegal;
    logic        imemReq, dmemReq, dmemWe;

    opclass u_opclass (
        .opcode_i  (OpCode),
        .opClass_o (opClass),
        .legal_o   (opLegal)
    );

    // State and retire counter. Reset drops straight back to FETCH, which
    // abandons any data access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Next-state and control outputs. Everything defaults to idle; while
    // rst_n is low nothing is requested even though the state reads FETCH,
    // so the first fetch request appears in the cycle after release.
    always_comb begin
        state_d   = state_q;
        imemReq   = 1'b0;
        dmemReq   = 1'b0;
        dmemWe    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        pc_sel    = PC_PLUS4;
        imm_sel   = IMM_I;
        alu_a_sel = ALUA_RS1;
        alu_b_sel = ALUB_RS2;
        wb_sel    = WB_ALU;
        retire    = 1'b0;

        // Operand selects follow the instruction class through EXEC, MEM
        // and WB so the ALU result stays stable until it is consumed.
        if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
            case (opClass)
                CLS_ALU_I: begin alu_b_sel = ALUB_IMM; imm_sel = IMM_I; end
                CLS_LOAD:  begin alu_b_sel = ALUB_IMM; imm_sel = IMM_I; end
                CLS_STORE: begin alu_b_sel = ALUB_IMM; imm_sel = IMM_S; end
                CLS_LUI:   begin alu_a_sel = ALUA_ZERO; alu_b_sel = ALUB_IMM; imm_sel = IMM_U; end
                CLS_AUIPC: begin alu_a_sel = ALUA_PC;   alu_b_sel = ALUB_IMM; imm_sel = IMM_U; end
                CLS_BRANCH: imm_sel = IMM_B;
                CLS_JAL:    imm_sel = IMM_J;
                CLS_JALR:  begin alu_b_sel = ALUB_IMM; imm_sel = IMM_I; end
                default: ;
            endcase
        end

        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    imemReq = 1'b1;
                    if (memBus.imem_valid) begin
                        ir_we   = 1'b1;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_d = opLegal ? ST_EXEC : ST_TRAP;
                end
                ST_EXEC: begin
                    case (opClass)
                        CLS_ALU_R, CLS_ALU_I, CLS_LUI, CLS_AUIPC: state_d = ST_WB;
                        CLS_LOAD, CLS_STORE:                      state_d = ST_MEM;
                        CLS_BRANCH: begin
                            pc_we   = 1'b1;
                            pc_sel  = br_taken ? PC_IMM : PC_PLUS4;
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end
                        CLS_JAL: begin
                            reg_we  = 1'b1;
                            wb_sel  = WB_PC4;
                            pc_we   = 1'b1;
                            pc_sel  = PC_IMM;
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end
                        CLS_JALR: begin
                            // Only funct3 = 000 is a defined JALR encoding.
                            if (funct3 != 3'b000) begin
                                state_d = ST_TRAP;
                            end else begin
                                reg_we  = 1'b1;
                                wb_sel  = WB_PC4;
                                pc_we   = 1'b1;
                                pc_sel  = PC_ALU;
                                retire  = 1'b1;
                                state_d = ST_FETCH;
                            end
                        end
                        CLS_FENCE: begin
                            pc_we   = 1'b1;
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end
                        default: state_d = ST_TRAP;
                    endcase
                end
                ST_MEM: begin
                    dmemReq = 1'b1;
                    dmemWe  = (opClass == CLS_STORE);
                    if (memBus.dmem_ready && isMemClass(opClass)) begin
                        if (opClass == CLS_STORE) begin
                            pc_we   = 1'b1;
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    reg_we  = 1'b1;
                    wb_sel  = (opClass == CLS_LOAD) ? WB_MEM : WB_ALU;
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
                ST_TRAP: begin
                    state_d = ST_TRAP;
                end
                default: state_d = ST_TRAP;
            endcase
        end

        instret_d = instret_q + {31'd0, retire};
    end

    assign memBus.imem_req = imemReq;
    assign memBus.dmem_req = dmemReq;
    assign memBus.dmem_we  = dmemWe;
    assign instret         = instret_q;
    assign trap            = (state_q == ST_TRAP);
    assign state           = state_q;

endmodule
